// File: rtl/debug_slave_jtag_driver.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// debug_slave_jtag_driver
//
// Drives the Nios II debug slave's virtual-JTAG interface from fabric logic.
// Each accepted (IR, DR) command runs the sequence UIR, CDR, SDR, UDR and RTI
// on a divided test clock. The DR word is shifted out LSB first, tdo is
// captured into a response word, and the response is returned over a
// valid/ready handshake.
//
// Ports
//   clk, reset_n         system clock, synchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; cmd_ir/cmd_dr are command payload
//   rsp_valid/rsp_ready  response handshake; rsp_dr is the captured tdo word
//   busy                 a command is in flight (accept to response handshake)
//   vji_tck/tdi/tdo      generated test clock and serial data
//   vji_ir_in            virtual IR presented to the slave
//   vji_uir/cdr/sdr/udr/rti  one-hot virtual-JTAG state flags
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a command
// UIR   | update-IR, one tck period
// CDR   | capture-DR, one tck period
// SDR   | shift-DR, DR_WIDTH tck periods, one bit per period
// UDR   | update-DR, one tck period
// RTI   | run-test-idle, RTI_PERIODS tck periods
// RESP  | response held until rsp_ready
// ----------------------------------------------------------------------------
module debug_slave_jtag_driver #(
    parameter int DR_WIDTH    = 38,
    parameter int IR_WIDTH    = 2,
    parameter int TCK_DIV     = 2,
    parameter int RTI_PERIODS = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic                busy,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UIR,
        S_CDR,
        S_SDR,
        S_UDR,
        S_RTI,
        S_RESP
    } state_t;

    localparam int DIV_W   = $clog2(2 * TCK_DIV) + 1;
    localparam int PER_MAX = (DR_WIDTH > RTI_PERIODS) ? DR_WIDTH : RTI_PERIODS;
    localparam int PER_W   = $clog2(PER_MAX) + 1;

    // The divider counts down through one tck period: the upper half of the
    // count is the tck-low phase, the lower half the tck-high phase.
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(2 * TCK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(TCK_DIV);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [PER_W-1:0] PER_SDR  = PER_W'(DR_WIDTH - 1);
    localparam logic [PER_W-1:0] PER_RTI  = PER_W'(RTI_PERIODS - 1);
    localparam logic [PER_W-1:0] PER_ONE  = PER_W'(1);

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [PER_W-1:0]      per_q, per_d;
    logic [DR_WIDTH-1:0]   tx_q, tx_d;
    logic [DR_WIDTH-1:0]   rx_q, rx_d;
    logic [DR_WIDTH-1:0]   rsp_dr_q, rsp_dr_d;
    logic [IR_WIDTH-1:0]   ir_q, ir_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  busy_q, busy_d;
    logic                  tck_q, tck_d;
    logic                  tdi_q, tdi_d;
    logic                  uir_q, uir_d;
    logic                  cdr_q, cdr_d;
    logic                  sdr_q, sdr_d;
    logic                  udr_q, udr_d;
    logic                  rti_q, rti_d;

    logic [DR_WIDTH-1:0]   tx_shift;
    logic                  period_end;
    logic                  tck_rise;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        per_d       = per_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rsp_dr_d    = rsp_dr_q;
        ir_d        = ir_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        busy_d      = busy_q;
        tck_d       = tck_q;
        tdi_d       = tdi_q;
        tx_shift    = tx_q >> 1;
        period_end  = (div_q == '0);
        tck_rise    = (div_q == DIV_RISE);

        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = S_UIR;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    ir_d        = cmd_ir;
                    tx_d        = cmd_dr;
                    rx_d        = '0;
                    div_d       = DIV_LOAD;
                    per_d       = '0;
                    tck_d       = 1'b0;
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end

            default: begin
                if (period_end) begin
                    div_d = DIV_LOAD;
                    tck_d = 1'b0;
                    if (per_q != '0) begin
                        per_d = per_q - PER_ONE;
                        if (state_q == S_SDR) begin
                            tx_d  = tx_shift;
                            tdi_d = tx_shift[0];
                        end
                    end else begin
                        case (state_q)
                            S_UIR: begin
                                state_d = S_CDR;
                                per_d   = '0;
                            end
                            S_CDR: begin
                                state_d = S_SDR;
                                per_d   = PER_SDR;
                                tdi_d   = tx_q[0];
                            end
                            S_SDR: begin
                                state_d = S_UDR;
                                per_d   = '0;
                                tx_d    = tx_shift;
                                tdi_d   = 1'b0;
                            end
                            S_UDR: begin
                                state_d = S_RTI;
                                per_d   = PER_RTI;
                            end
                            default: begin
                                state_d     = S_RESP;
                                rsp_valid_d = 1'b1;
                                rsp_dr_d    = rx_q;
                                ir_d        = '0;
                            end
                        endcase
                    end
                end else begin
                    div_d = div_q - DIV_ONE;
                    if (tck_rise) begin
                        tck_d = 1'b1;
                        // Shifting in at the MSB puts the period-k sample at
                        // bit k once all DR_WIDTH periods are done.
                        if (state_q == S_SDR) begin
                            rx_d               = rx_q >> 1;
                            rx_d[DR_WIDTH-1]   = vji_tdo;
                        end
                    end
                end
            end
        endcase

        uir_d = (state_d == S_UIR);
        cdr_d = (state_d == S_CDR);
        sdr_d = (state_d == S_SDR);
        udr_d = (state_d == S_UDR);
        rti_d = (state_d == S_RTI);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            per_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            rsp_dr_q    <= '0;
            ir_q        <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            tck_q       <= 1'b0;
            tdi_q       <= 1'b0;
            uir_q       <= 1'b0;
            cdr_q       <= 1'b0;
            sdr_q       <= 1'b0;
            udr_q       <= 1'b0;
            rti_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            per_q       <= per_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rsp_dr_q    <= rsp_dr_d;
            ir_q        <= ir_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            tck_q       <= tck_d;
            tdi_q       <= tdi_d;
            uir_q       <= uir_d;
            cdr_q       <= cdr_d;
            sdr_q       <= sdr_d;
            udr_q       <= udr_d;
            rti_q       <= rti_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dr    = rsp_dr_q;
    assign busy      = busy_q;
    assign vji_tck   = tck_q;
    assign vji_tdi   = tdi_q;
    assign vji_ir_in = ir_q;
    assign vji_uir   = uir_q;
    assign vji_cdr   = cdr_q;
    assign vji_sdr   = sdr_q;
    assign vji_udr   = udr_q;
    assign vji_rti   = rti_q;

endmodule

// File: tb/tb_debug_slave_jtag_driver.sv
`timescale 1ns/1ps
// Bench for debug_slave_jtag_driver: a default instance driven against a
// behavioural debug-slave shift register, plus a TCK_DIV=1 / RTI_PERIODS=3
// instance for the fast-clock case.
module tb_debug_slave_jtag_driver;

    localparam int DRW = 38;
    localparam logic [DRW-1:0] CAP   = 38'h2_AAAA_5555;
    localparam logic [DRW-1:0] CAP_B = 38'h19_E26A_F37B;
    localparam logic [DRW-1:0] DR_A  = 38'h3_1234_5678;
    localparam logic [DRW-1:0] X1    = 38'h15_5A5A_C3C3;
    localparam logic [DRW-1:0] X2    = 38'h2B_0F0F_1234;
    localparam logic [DRW-1:0] X3    = 38'h3F_0000_FFFF;
    localparam logic [DRW-1:0] ONES  = '1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    logic           reset_n;
    logic           cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
    logic [1:0]     cmd_ir, vji_ir_in;
    logic [DRW-1:0] cmd_dr, rsp_dr;
    logic           vji_tck, vji_tdi, vji_tdo;
    logic           vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    logic           cmd_valid_b, cmd_ready_b, rsp_valid_b, rsp_ready_b, busy_b;
    logic [1:0]     cmd_ir_b, vji_ir_in_b;
    logic [DRW-1:0] cmd_dr_b, rsp_dr_b;
    logic           vji_tck_b, vji_tdi_b, vji_tdo_b;
    logic           vji_uir_b, vji_cdr_b, vji_sdr_b, vji_udr_b, vji_rti_b;

    debug_slave_jtag_driver dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .busy(busy),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr),
        .vji_rti(vji_rti)
    );

    debug_slave_jtag_driver #(.DR_WIDTH(DRW), .IR_WIDTH(2), .TCK_DIV(1), .RTI_PERIODS(3)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_ir(cmd_ir_b), .cmd_dr(cmd_dr_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_dr(rsp_dr_b), .busy(busy_b),
        .vji_tck(vji_tck_b), .vji_tdi(vji_tdi_b), .vji_tdo(vji_tdo_b), .vji_ir_in(vji_ir_in_b),
        .vji_uir(vji_uir_b), .vji_cdr(vji_cdr_b), .vji_sdr(vji_sdr_b), .vji_udr(vji_udr_b),
        .vji_rti(vji_rti_b)
    );

    // Debug-slave models: capture on CDR, shift on tck rise in SDR, tdo=sr[0].
    logic [DRW-1:0] sl_sr = '0, sl_udr = '0, sl_sr_b = '0;
    bit cap_en = 1'b1;
    int sdr_rise_b = 0;

    always @(posedge vji_tck) begin
        if (vji_cdr) begin
            if (cap_en) sl_sr <= CAP;
        end else if (vji_sdr) begin
            sl_sr <= {vji_tdi, sl_sr[DRW-1:1]};
        end else if (vji_udr) begin
            sl_udr <= sl_sr;
        end
    end
    assign vji_tdo = sl_sr[0];

    always @(posedge vji_tck_b) begin
        if (vji_cdr_b) sl_sr_b <= CAP_B;
        else if (vji_sdr_b) begin
            sl_sr_b    <= {vji_tdi_b, sl_sr_b[DRW-1:1]};
            sdr_rise_b <= sdr_rise_b + 1;
        end
    end
    assign vji_tdo_b = sl_sr_b[0];

    logic [DRW-1:0] exp_q[$];
    logic [DRW-1:0] exp_qb[$];

    task automatic send_cmd(input logic [1:0] ir, input logic [DRW-1:0] dr,
                            input bit push, input logic [DRW-1:0] exp, output int acc);
        logic [DRW-1:0] junk;
        cmd_ir = ir; cmd_dr = dr; cmd_valid = 1'b1; acc = -1;
        for (int i = 0; i < 400; i++) begin
            if (cmd_ready) begin
                @(posedge clk); #1;
                acc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        junk = {$urandom, $urandom};
        cmd_dr = junk;
        cmd_ir = ~ir;
        vectors++;
        if (acc < 0) begin
            miscompares++;
            $display("FAIL accept: cmd_ready never high within 400 cycles, required accept");
        end else if (push) exp_q.push_back(exp);
    endtask

    task automatic wait_rsp(input int acc, input int lat_exp);
        int t;
        logic [DRW-1:0] e;
        t = -1;
        for (int i = 0; i < 400; i++) begin
            if (rsp_valid) begin t = cyc; break; end
            @(posedge clk); #1;
        end
        vectors++;
        if (t - acc != lat_exp) begin
            miscompares++;
            $display("FAIL latency: got %0d cycles, required %0d", t - acc, lat_exp);
        end
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL rsp_dr: got %h with no expected entry, required none", rsp_dr);
        end else begin
            e = exp_q.pop_front();
            if (rsp_dr !== e) begin
                miscompares++;
                $display("FAIL rsp_dr: got %h, required %h", rsp_dr, e);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        vectors++;
        if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL handshake: {rsp_valid,busy,cmd_ready} got %b, required 001",
                     {rsp_valid, busy, cmd_ready});
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if ({cmd_ready, rsp_valid, rsp_dr, busy, vji_tck, vji_tdi, vji_ir_in,
                 vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs: cycle %0d outputs nonzero (cmd_ready=%b busy=%b tck=%b), required all 0",
                         i, cmd_ready, busy, vji_tck);
            end
        end
        reset_n = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({cmd_ready, busy, cmd_ready_b, busy_b} !== 4'b1010) begin
            miscompares++;
            $display("FAIL reset_release: {cmd_ready,busy,cmd_ready_b,busy_b} got %b, required 1010",
                     {cmd_ready, busy, cmd_ready_b, busy_b});
        end
    endtask

    task automatic test_single();
        int acc, p, ph;
        logic [4:0] st;
        logic [10:0] got, exp;
        logic t;
        send_cmd(2'b01, DR_A, 1'b1, CAP, acc);
        for (int i = 0; i < 168; i++) begin
            p  = i / 4;
            ph = i % 4;
            if (p == 0)       st = 5'b10000;
            else if (p == 1)  st = 5'b01000;
            else if (p < 40)  st = 5'b00100;
            else if (p == 40) st = 5'b00010;
            else              st = 5'b00001;
            t   = (p >= 2 && p < 40) ? DR_A[p-2] : 1'b0;
            exp = {st, (ph >= 2), t, 2'b01, 1'b0, 1'b1};
            got = {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_tck, vji_tdi,
                   vji_ir_in, rsp_valid, busy};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL seq cycle %0d: {uir,cdr,sdr,udr,rti,tck,tdi,ir,rsp_valid,busy} got %b, required %b",
                         i, got, exp);
            end
            @(posedge clk); #1;
        end
        wait_rsp(acc, 168);
        vectors++;
        if (sl_udr !== DR_A) begin
            miscompares++;
            $display("FAIL slave_udr: got %h, required %h", sl_udr, DR_A);
        end
    endtask

    task automatic test_backpressure();
        int acc, t;
        send_cmd(2'b10, X1, 1'b1, CAP, acc);
        t = -1;
        for (int i = 0; i < 400; i++) begin
            if (rsp_valid) begin t = cyc; break; end
            @(posedge clk); #1;
        end
        vectors++;
        if (t - acc != 168) begin
            miscompares++;
            $display("FAIL bp_latency: got %0d, required 168", t - acc);
        end
        cmd_ir = 2'b11; cmd_dr = X2; cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            vectors++;
            if ({rsp_valid, cmd_ready, busy} !== 3'b101 || exp_q.size() == 0 || rsp_dr !== exp_q[0]) begin
                miscompares++;
                $display("FAIL bp_hold cycle %0d: {rsp_valid,cmd_ready,busy} got %b rsp_dr %h, required 101 and %h",
                         i, {rsp_valid, cmd_ready, busy}, rsp_dr, CAP);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        vectors++;
        if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
            miscompares++;
            $display("FAIL bp_release: {rsp_valid,cmd_ready,busy} got %b, required 010",
                     {rsp_valid, cmd_ready, busy});
        end
        @(posedge clk); #1;
        acc = cyc;
        cmd_valid = 1'b0;
        vectors++;
        if ({busy, cmd_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL bp_second_accept: {busy,cmd_ready} got %b, required 10", {busy, cmd_ready});
        end
        exp_q.push_back(CAP);
        wait_rsp(acc, 168);
    endtask

    task automatic test_back_to_back();
        int acc1, acc2;
        logic [DRW-1:0] e;
        cap_en = 1'b0;
        rsp_ready = 1'b1;
        send_cmd(2'b11, '0, 1'b1, X2, acc1);
        cmd_dr = ONES; cmd_valid = 1'b1;
        for (int i = 0; i < 400 && !rsp_valid; i++) begin
            @(posedge clk); #1;
        end
        vectors++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        if (!rsp_valid || rsp_dr !== e) begin
            miscompares++;
            $display("FAIL b2b_first: rsp_valid %b rsp_dr %h, required 1 and %h", rsp_valid, rsp_dr, e);
        end
        acc2 = -1;
        for (int i = 0; i < 10; i++) begin
            if (cmd_ready) begin
                @(posedge clk); #1;
                acc2 = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        exp_q.push_back('0);
        vectors++;
        if (acc2 - acc1 != 170) begin
            miscompares++;
            $display("FAIL b2b_interval: got %0d, required 170", acc2 - acc1);
        end
        wait_rsp(acc2, 168);
        rsp_ready = 1'b0;
        cap_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int acc;
        send_cmd(2'b01, X3, 1'b0, '0, acc);
        repeat (52) @(posedge clk);
        #1;
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if ({vji_sdr, vji_tck, vji_tdi, vji_ir_in, rsp_valid, busy, cmd_ready} !== '0) begin
                miscompares++;
                $display("FAIL mid_reset cycle %0d: {sdr,tck,tdi,ir,rsp_valid,busy,cmd_ready} got %b, required 0",
                         i, {vji_sdr, vji_tck, vji_tdi, vji_ir_in, rsp_valid, busy, cmd_ready});
            end
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_rsp: rsp_valid got %b, required 0", rsp_valid);
        end
        send_cmd(2'b10, X1, 1'b1, CAP, acc);
        wait_rsp(acc, 168);
    endtask

    task automatic test_fast_tck();
        int acc;
        logic [DRW-1:0] e;
        cmd_ir_b = 2'b01; cmd_dr_b = X2; cmd_valid_b = 1'b1;
        sdr_rise_b = 0;
        vectors++;
        if (cmd_ready_b !== 1'b1) begin
            miscompares++;
            $display("FAIL fast_ready: cmd_ready_b got %b, required 1", cmd_ready_b);
        end
        @(posedge clk); #1;
        acc = cyc;
        cmd_valid_b = 1'b0;
        exp_qb.push_back(CAP_B);
        for (int i = 0; i < 88; i++) begin
            vectors++;
            if ({vji_tck_b, rsp_valid_b, busy_b} !== {((i % 2) == 1), 1'b0, 1'b1}) begin
                miscompares++;
                $display("FAIL fast_tck cycle %0d: {tck,rsp_valid,busy} got %b, required %b",
                         i, {vji_tck_b, rsp_valid_b, busy_b}, {((i % 2) == 1), 1'b0, 1'b1});
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (rsp_valid_b !== 1'b1 || cyc - acc != 88) begin
            miscompares++;
            $display("FAIL fast_latency: rsp_valid_b %b at %0d, required 1 at 88", rsp_valid_b, cyc - acc);
        end
        e = exp_qb.pop_front();
        vectors++;
        if (rsp_dr_b !== e) begin
            miscompares++;
            $display("FAIL fast_rsp_dr: got %h, required %h", rsp_dr_b, e);
        end
        vectors++;
        if (sdr_rise_b != DRW) begin
            miscompares++;
            $display("FAIL fast_samples: got %0d sdr tck rises, required %0d", sdr_rise_b, DRW);
        end
        rsp_ready_b = 1'b1;
        @(posedge clk); #1;
        rsp_ready_b = 1'b0;
        vectors++;
        if ({rsp_valid_b, busy_b, cmd_ready_b} !== 3'b001) begin
            miscompares++;
            $display("FAIL fast_handshake: got %b, required 001", {rsp_valid_b, busy_b, cmd_ready_b});
        end
    endtask

    initial begin
        reset_n = 1'b0;
        cmd_valid = 1'b1; cmd_ir = '0; cmd_dr = '0; rsp_ready = 1'b0;
        cmd_valid_b = 1'b0; cmd_ir_b = '0; cmd_dr_b = '0; rsp_ready_b = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_fast_tck();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
